twiddle_mult_pipe: RTL and testbench

- Pipelined complex twiddle multiplier: computes (in_re + j·in_im) · W[k], where W[k] = exp(-j·2πk/(2N)), for k in 0..N-1.
- Parametrised in data width, twiddle width/fraction and table depth.
- Adds valid/ready flow control, rounding, overflow reporting, and an internal strided index generator alongside an external index.
- Sits between butterfly stages of the FFT datapath.

---
 rtl/fft_pkg.sv | 45 ++++
 rtl/twiddle_rom.sv | 53 +++++
 rtl/twiddle_mult_pipe.sv | 160 ++++++++++++++++
 tb/tb_twiddle_mult_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and elaboration-time helpers for the FFT
// datapath twiddle stage (twiddle table generation, rounding constant,
// product/sum widths).
package fft_pkg;

  localparam real PI = 3.14159265358979323846;

  // Widths for the default configuration (BW=16, TW_BW=12). Parameterised
  // instances use prod_w()/sum_w() with their own parameters.
  localparam int DEF_BW    = 16;
  localparam int DEF_TW_BW = 12;
  localparam int PROD_W    = DEF_BW + 1 + DEF_TW_BW;
  localparam int SUM_W     = PROD_W + 1;

  function automatic int prod_w(input int bw, input int tw_bw);
    return bw + 1 + tw_bw;
  endfunction

  function automatic int sum_w(input int bw, input int tw_bw);
    return bw + 2 + tw_bw;
  endfunction

  function automatic real tw_scale(input int frac);
    real s;
    s = 1.0;
    for (int i = 0; i < frac; i++) s = s * 2.0;
    return s;
  endfunction

  // W_re[k] = floor(2^frac * cos(pi*k/n))
  function automatic int tw_re(input int k, input int n, input int frac);
    return $rtoi($floor(tw_scale(frac) * $cos(PI * k / n)));
  endfunction

  // W_im[k] = floor(-2^frac * sin(pi*k/n))
  function automatic int tw_im(input int k, input int n, input int frac);
    return $rtoi($floor(-tw_scale(frac) * $sin(PI * k / n)));
  endfunction

  // Half-LSB of the post-shift result, for round-half-up.
  function automatic int rnd_const(input int frac);
    return (frac > 0) ? (1 << (frac - 1)) : 0;
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// twiddle_rom: constant table of W[k] = exp(-j*pi*k/N) in TW_FRAC fixed
// point, built at elaboration; registered read gated by rd_en.
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int N       = 64,
  parameter int TW_BW   = 12,
  parameter int TW_FRAC = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rd_en,
  input  logic [$clog2(N)-1:0]     k,
  output logic signed [TW_BW-1:0]  w_re,
  output logic signed [TW_BW-1:0]  w_im
);

  logic signed [TW_BW-1:0] tab_re [N];
  logic signed [TW_BW-1:0] tab_im [N];
  logic signed [TW_BW-1:0] w_re_d, w_re_q, w_im_d, w_im_q;

  for (genvar g = 0; g < N; g++) begin : g_tab
    localparam int RE = tw_re(g, N, TW_FRAC);
    localparam int IM = tw_im(g, N, TW_FRAC);
    assign tab_re[g] = TW_BW'(RE);
    assign tab_im[g] = TW_BW'(IM);
  end

  // look up the next twiddle only when the pipeline advances
  always_comb begin
    w_re_d = w_re_q;
    w_im_d = w_im_q;
    if (rd_en) begin
      w_re_d = tab_re[k];
      w_im_d = tab_im[k];
    end
  end

  // read register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_re_q <= '0;
      w_im_q <= '0;
    end else begin
      w_re_q <= w_re_d;
      w_im_q <= w_im_d;
    end
  end

  assign w_re = w_re_q;
  assign w_im = w_im_q;

endmodule

// File: rtl/twiddle_mult_pipe.sv
// twiddle_mult_pipe: 3-stage complex multiply by W[k] with valid/ready,
// round-half-up, overflow flag and a strided internal index generator.
// Build option: define TWIDDLE_MULT_SAT_EN to clamp out-of-range results
// instead of wrapping to the low BW+1 bits.
module twiddle_mult_pipe
  import fft_pkg::*;
#(
  parameter int BW      = 16,
  parameter int N       = 64,
  parameter int TW_BW   = 12,
  parameter int TW_FRAC = 10,
  localparam int IW     = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [BW:0]   in_re,
  input  logic signed [BW:0]   in_im,
  input  logic [IW-1:0]        in_idx,
  input  logic                 in_last,
  input  logic                 idx_sel,
  input  logic [IW-1:0]        stride,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [BW:0]   out_re,
  output logic signed [BW:0]   out_im,
  output logic                 out_ovf
);

  localparam int STAGES = 3;
  localparam int DW     = BW + 1;
  localparam int PW     = prod_w(BW, TW_BW);
  localparam int SW     = sum_w(BW, TW_BW);

  localparam logic signed [SW-1:0] RND  = SW'(rnd_const(TW_FRAC));
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** BW) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(2 ** BW));
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {BW{1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {BW{1'b0}}};

  logic                    advance, accept;
  logic [STAGES:1]         vld_pipe_d, vld_pipe_q;
  logic [IW-1:0]           acc_d, acc_q, k_sel;
  logic signed [DW-1:0]    s1_re_d, s1_re_q, s1_im_d, s1_im_q;
  logic signed [TW_BW-1:0] w_re, w_im;
  logic signed [PW-1:0]    rr_d, rr_q, ii_d, ii_q, ri_d, ri_q, ir_d, ir_q;
  logic signed [SW-1:0]    sum_re, sum_im, sh_re, sh_im;
  logic                    hi_re, lo_re, hi_im, lo_im;
  logic signed [DW-1:0]    res_re, res_im;
  logic signed [DW-1:0]    out_re_d, out_re_q, out_im_d, out_im_q;
  logic                    out_ovf_d, out_ovf_q;

  // the whole pipe moves together; it only stalls when the output is held
  assign advance  = !vld_pipe_q[STAGES] || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign k_sel    = idx_sel ? acc_q : in_idx;

  twiddle_rom #(
    .N       (N),
    .TW_BW   (TW_BW),
    .TW_FRAC (TW_FRAC)
  ) u_rom (
    .clk   (clk),
    .rstn  (rstn),
    .rd_en (advance),
    .k     (k_sel),
    .w_re  (w_re),
    .w_im  (w_im)
  );

  // valid shift register and strided index accumulator (last beat restarts it)
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    acc_d      = acc_q;
    if (advance) vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
    if (accept)  acc_d = in_last ? '0 : acc_q + stride;
  end

  // S1 sample capture and S2 partial products (twiddle arrives with S1)
  always_comb begin
    s1_re_d = s1_re_q;
    s1_im_d = s1_im_q;
    rr_d    = rr_q;
    ii_d    = ii_q;
    ri_d    = ri_q;
    ir_d    = ir_q;
    if (advance) begin
      s1_re_d = in_re;
      s1_im_d = in_im;
      rr_d    = PW'(s1_re_q) * PW'(w_re);
      ii_d    = PW'(s1_im_q) * PW'(w_im);
      ri_d    = PW'(s1_re_q) * PW'(w_im);
      ir_d    = PW'(s1_im_q) * PW'(w_re);
    end
  end

  // S3: combine, round half up, rescale, range check, wrap or clamp
  always_comb begin
    sum_re = SW'(rr_q) - SW'(ii_q);
    sum_im = SW'(ri_q) + SW'(ir_q);
    sh_re  = (sum_re + RND) >>> TW_FRAC;
    sh_im  = (sum_im + RND) >>> TW_FRAC;
    hi_re  = sh_re > MAXV;
    lo_re  = sh_re < MINV;
    hi_im  = sh_im > MAXV;
    lo_im  = sh_im < MINV;
`ifdef TWIDDLE_MULT_SAT_EN
    res_re = hi_re ? SAT_MAX : (lo_re ? SAT_MIN : sh_re[DW-1:0]);
    res_im = hi_im ? SAT_MAX : (lo_im ? SAT_MIN : sh_im[DW-1:0]);
`else
    res_re = sh_re[DW-1:0];
    res_im = sh_im[DW-1:0];
`endif
    out_re_d  = out_re_q;
    out_im_d  = out_im_q;
    out_ovf_d = out_ovf_q;
    if (advance) begin
      out_re_d  = res_re;
      out_im_d  = res_im;
      out_ovf_d = hi_re | lo_re | hi_im | lo_im;
    end
  end

  // pipeline registers; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
      acc_q      <= '0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      rr_q       <= '0;
      ii_q       <= '0;
      ri_q       <= '0;
      ir_q       <= '0;
      out_re_q   <= '0;
      out_im_q   <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      acc_q      <= acc_d;
      s1_re_q    <= s1_re_d;
      s1_im_q    <= s1_im_d;
      rr_q       <= rr_d;
      ii_q       <= ii_d;
      ri_q       <= ri_d;
      ir_q       <= ir_d;
      out_re_q   <= out_re_d;
      out_im_q   <= out_im_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign out_valid = vld_pipe_q[STAGES];
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// tb_twiddle_mult_pipe: scoreboard bench for twiddle_mult_pipe (defaults).
module tb_twiddle_mult_pipe;

  localparam int BW = 16, N = 64, TW_BW = 12, TW_FRAC = 10, IW = 6;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rstn;
  logic in_valid, in_ready, in_last, idx_sel, out_valid, out_ready, out_ovf;
  logic signed [BW:0] in_re, in_im, out_re, out_im;
  logic [IW-1:0] in_idx, stride;

  always #5 clk = ~clk;

  twiddle_mult_pipe #(.BW(BW), .N(N), .TW_BW(TW_BW), .TW_FRAC(TW_FRAC)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_idx(in_idx), .in_last(in_last),
    .idx_sel(idx_sel), .stride(stride), .out_valid(out_valid),
    .out_ready(out_ready), .out_re(out_re), .out_im(out_im), .out_ovf(out_ovf)
  );

  typedef struct { int re; int im; bit ovf; int cyc; bit lat; bit gap; } exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_emit = 0, emit_cnt = 0, acc_cnt = 0;
  int twr[N], twi[N];

  // what the driver says the current beat should produce
  int drv_k, drv_ere, drv_eim;
  bit drv_use_exp, drv_eovf, drv_lat, drv_gap;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int fold(input longint v, output bit hi, output bit lo);
    longint w;
    hi = v > 65535;
    lo = v < -65536;
`ifdef TWIDDLE_MULT_SAT_EN
    if (hi) return 65535;
    if (lo) return -65536;
    return int'(v);
`else
    w = v & 64'h1FFFF;
    if (w >= 65536) w = w - 131072;
    return int'(w);
`endif
  endfunction

  function automatic exp_t model(input int a, input int b, input int k);
    exp_t e;
    longint sr, si;
    bit h1, l1, h2, l2;
    sr = longint'(a) * twr[k] - longint'(b) * twi[k];
    si = longint'(a) * twi[k] + longint'(b) * twr[k];
    sr = (sr + 512) >>> 10;
    si = (si + 512) >>> 10;
    e.re = fold(sr, h1, l1);
    e.im = fold(si, h2, l2);
    e.ovf = h1 | l1 | h2 | l2;
    return e;
  endfunction

  // scoreboard: pop on output handshake, push on input handshake
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rstn === 1'b1) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          e = q.pop_front();
          chk("out_re", out_re, e.re);
          chk("out_im", out_im, e.im);
          chk("out_ovf", out_ovf, e.ovf);
          if (e.lat) chk("latency", cyc - e.cyc, 3);
          if (e.gap) chk("gap", cyc - last_emit, 1);
        end
        last_emit = cyc;
        emit_cnt++;
      end
      if (in_valid && in_ready) begin
        e = model(in_re, in_im, drv_k);
        if (drv_use_exp) begin e.re = drv_ere; e.im = drv_eim; e.ovf = drv_eovf; end
        e.cyc = cyc; e.lat = drv_lat; e.gap = drv_gap;
        q.push_back(e);
        acc_cnt++;
      end
    end
  end

  task automatic send(input int re, input int im, input int idx, input bit sel,
                      input bit last, input int k, input bit ue, input int ere,
                      input int eim, input bit eovf, input bit lat, input bit gap);
    int n;
    in_valid = 1; in_re = (BW+1)'(re); in_im = (BW+1)'(im);
    in_idx = IW'(idx); idx_sel = sel; in_last = last;
    drv_k = k; drv_use_exp = ue; drv_ere = ere; drv_eim = eim; drv_eovf = eovf;
    drv_lat = lat; drv_gap = gap;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin n++; @(negedge clk); end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic sendx(input int re, input int im, input int idx, input int ere,
                       input int eim, input bit eovf, input bit lat);
    send(re, im, idx, 0, 0, idx, 1, ere, eim, eovf, lat, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin n++; @(posedge clk); end
    #1;
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int a, b, snap;
    bit rnd_done;
    for (int k = 0; k < N; k++) begin
      twr[k] = $rtoi($floor(1024.0 * $cos(PI * k / N)));
      twi[k] = $rtoi($floor(-1024.0 * $sin(PI * k / N)));
    end
    rstn = 0; in_valid = 0; in_re = 0; in_im = 0; in_idx = 0; in_last = 0;
    idx_sel = 0; stride = 0; out_ready = 1;
    drv_k = 0; drv_use_exp = 0; drv_lat = 0; drv_gap = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1; rstn = 1;
    repeat (2) @(posedge clk); #1;

    // directed values from the plan
    sendx(1000, -500, 0, 1000, -500, 0, 1);
    drain();
    sendx(1000, -500, 32, -500, -1000, 0, 0);
    sendx(1024, 0, 16, 724, -725, 0, 0);
`ifdef TWIDDLE_MULT_SAT_EN
    sendx(-65536, -65536, 16, -65536, 64, 1, 0);
`else
    sendx(-65536, -65536, 16, 38336, 64, 1, 0);
`endif
    drain();

    // backpressure: 3 fit, then stall; all 5 then stream out back to back
    out_ready = 0;
    snap = acc_cnt;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(100 * i + 7, -300 + 11 * i, 5 * i + 1, 0, 0, 5 * i + 1, 0, 0, 0, 0, 0, i != 0);
      end
      begin
        repeat (8) @(negedge clk);
        chk("bp_accepted", acc_cnt - snap, 3);
        chk("bp_in_ready", in_ready, 0);
        @(posedge clk); #1; out_ready = 1;
      end
    join
    drain();

    // random traffic with random downstream stalls
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          case ($urandom_range(0, 3))
            0: a = ($urandom_range(0, 1) != 0) ? 65535 : -65536;
            default: a = int'($urandom_range(0, 131071)) - 65536;
          endcase
          b = int'($urandom_range(0, 131071)) - 65536;
          a = a; stride = IW'($urandom_range(0, 63));
          begin
            int k = int'($urandom_range(0, N - 1));
            send(a, b, k, 0, 0, k, 0, 0, 0, 0, 0, 0);
          end
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1;
      end
    join
    drain();

    // reset pulse clears the index accumulator, then internal indexing
    @(posedge clk); #1; rstn = 0;
    @(posedge clk); #1; rstn = 1; stride = 2;
    send(3000, -2000, 17, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    send(3100, -1900, 17, 1, 0, 2, 0, 0, 0, 0, 0, 0);
    send(3200, -1800, 17, 1, 1, 4, 0, 0, 0, 0, 0, 0);
    send(3300, -1700, 17, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    send(3400, -1600, 17, 1, 0, 2, 0, 0, 0, 0, 0, 0);
    drain();

    // reset with the pipe full: everything in flight vanishes
    idx_sel = 0; stride = 0; out_ready = 0;
    for (int i = 0; i < 3; i++) send(500 + i, 600 + i, i, 0, 0, i, 0, 0, 0, 0, 0, 0);
    rstn = 0;
    q.delete();
    @(posedge clk); @(negedge clk);
    chk("rst_full_out_valid", out_valid, 0);
    chk("rst_full_out_re", out_re, 0);
    @(posedge clk); #1; rstn = 1; out_ready = 1;
    snap = emit_cnt;
    repeat (10) @(negedge clk);
    chk("rst_no_stale", emit_cnt - snap, 0);
    chk("rst_in_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
